// File: rtl/intr_arbiter_if.sv
// Request, handshake and bus-control signals shared by the interrupt arbiter
// and the processor-side logic that drives it.
interface intr_arbiter_if #(
    parameter int NUM_SRC = 4
);
    logic               IE;
    logic [NUM_SRC-1:0] req;
    logic [31:0]        ABUS;
    logic               we;
    logic               intAck;
    logic               intDone;
    logic               IRQ;
    logic [3:0]         IDN;
    logic               busy;

    modport master (
        output IE, req, ABUS, we, intAck, intDone,
        input  IRQ, IDN, busy
    );

    modport slave (
        input  IE, req, ABUS, we, intAck, intDone,
        output IRQ, IDN, busy
    );
endinterface

// File: rtl/intr_arbiter.sv
// Fixed-priority interrupt arbiter: edge-captured sticky pending bits, a
// software mask, and a single in-flight IRQ/IDN with acknowledge/done handshake.
module intr_arbiter #(
    parameter int          NUM_SRC   = 4,
    parameter logic [31:0] ADDR_MASK = 32'hF000_0020,
    parameter logic [31:0] ADDR_PEND = 32'hF000_0024,
    parameter logic [3:0]  IDN_NONE  = 4'hF
) (
    input  logic          clk,
    input  logic          rst,
    inout  wire  [31:0]   DBUS,
    intr_arbiter_if.slave bus
);
    localparam int DATA_W = 32;
    localparam int CUR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

    state_t             state;
    state_t             stateNext;
    logic [NUM_SRC-1:0] reqD;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] rose;
    logic [NUM_SRC-1:0] clrVec;
    logic [NUM_SRC-1:0] curHot;
    logic [CUR_W-1:0]   cur;
    logic [CUR_W-1:0]   winner;
    logic               loadCur;
    logic               ackTaken;
    logic               wrMask;
    logic               wrPend;
    logic               rdEn;
    logic [DATA_W-1:0]  rdData;
    logic               irqOut;
    logic               busyOut;
    logic [3:0]         idnOut;
    logic               unusedDbus;

    // Index of the lowest set bit; source 0 (timer) has highest priority.
    function automatic logic [CUR_W-1:0] lowestSet(input logic [NUM_SRC-1:0] v);
        lowestSet = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (v[i]) lowestSet = CUR_W'(i);
    endfunction

    assign wrMask   = bus.we && (bus.ABUS == ADDR_MASK);
    assign wrPend   = bus.we && (bus.ABUS == ADDR_PEND);
    assign rose     = bus.req & ~reqD;
    assign eligible = pending & mask;
    assign winner   = lowestSet(eligible);
    assign curHot   = NUM_SRC'(1) << cur;
    assign ackTaken = (state == REQ) && bus.intAck;
    assign clrVec   = (wrPend ? DBUS[NUM_SRC-1:0] : '0) | (ackTaken ? curHot : '0);

    always_comb begin
        stateNext = state;
        loadCur   = 1'b0;
        irqOut    = 1'b0;
        busyOut   = 1'b0;
        idnOut    = 4'(cur) + 4'd1;
        case (state)
            IDLE: begin
                idnOut = IDN_NONE;
                if (bus.IE && |eligible) begin
                    stateNext = REQ;
                    loadCur   = 1'b1;
                end
            end
            REQ: begin
                irqOut = 1'b1;
                // A withdrawn enable leaves pending intact so the source re-arbitrates.
                if (bus.intAck)
                    stateNext = SVC;
                else if (!bus.IE || !mask[cur])
                    stateNext = IDLE;
            end
            SVC: begin
                busyOut = 1'b1;
                if (bus.intDone)
                    stateNext = IDLE;
            end
            default: begin
                idnOut    = IDN_NONE;
                stateNext = IDLE;
            end
        endcase
    end

    // Edge capture gives set priority over any clear arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            reqD    <= '0;
            pending <= '0;
            mask    <= '1;
            cur     <= '0;
        end else begin
            state   <= stateNext;
            reqD    <= bus.req;
            pending <= (pending & ~clrVec) | rose;
            if (wrMask)
                mask <= DBUS[NUM_SRC-1:0];
            if (loadCur)
                cur <= winner;
        end
    end

    assign bus.IRQ  = irqOut;
    assign bus.busy = busyOut;
    assign bus.IDN  = idnOut;

    assign rdEn   = !bus.we && ((bus.ABUS == ADDR_MASK) || (bus.ABUS == ADDR_PEND));
    assign rdData = (bus.ABUS == ADDR_MASK) ? DATA_W'(mask) : DATA_W'(pending);
    assign DBUS   = rdEn ? rdData : 'z;

    assign unusedDbus = ^DBUS[DATA_W-1:NUM_SRC];
endmodule

// File: tb/tb_intr_arbiter.sv
// Bench for intr_arbiter: directed scenarios followed by random traffic, all
// checked cycle by cycle against a behavioural model of the arbiter.
module tb_intr_arbiter;
    localparam int          NUM_SRC    = 4;
    localparam logic [31:0] ADDR_MASK  = 32'hF000_0020;
    localparam logic [31:0] ADDR_PEND  = 32'hF000_0024;
    localparam logic [31:0] ADDR_OTHER = 32'h0000_1000;
    localparam int          PH_NONE    = 0;
    localparam int          PH_OFFER   = 1;
    localparam int          PH_SERVICE = 2;

    logic        clk = 1'b0;
    logic        rst;
    wire  [31:0] DBUS;
    logic [31:0] tbData;
    logic        tbDrive;
    int          checks = 0;
    int          errors = 0;

    // Model state: pending/mask bits, previous request levels, phase and device number.
    logic [3:0]  mPend;
    logic [3:0]  mMask;
    logic [3:0]  mPrev;
    logic [3:0]  mIdn;
    int          mPhase;

    intr_arbiter_if #(.NUM_SRC(NUM_SRC)) ifc ();

    intr_arbiter #(
        .NUM_SRC  (NUM_SRC),
        .ADDR_MASK(ADDR_MASK),
        .ADDR_PEND(ADDR_PEND),
        .IDN_NONE (4'hF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .DBUS(DBUS),
        .bus (ifc)
    );

    assign DBUS = tbDrive ? tbData : 'z;

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
        ifc.ABUS = a;
        ifc.we   = 1'b1;
        tbData   = d;
        tbDrive  = 1'b1;
    endtask

    task automatic busRead(input logic [31:0] a);
        ifc.ABUS = a;
        ifc.we   = 1'b0;
        tbData   = 32'h0;
        tbDrive  = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic modelStep();
        logic [3:0] oldElig;
        logic [3:0] clr;
        int         idx;
        if (rst) begin
            mPend  = 4'h0;
            mMask  = 4'hF;
            mPrev  = 4'h0;
            mPhase = PH_NONE;
            mIdn   = 4'hF;
            return;
        end
        oldElig = mPend & mMask;
        idx     = int'(mIdn) - 1;
        clr     = 4'h0;
        if (ifc.we && ifc.ABUS == ADDR_PEND)
            clr = tbData[3:0];
        if (mPhase == PH_OFFER && ifc.intAck)
            clr[idx] = 1'b1;
        case (mPhase)
            PH_NONE: begin
                if (ifc.IE && oldElig != 4'h0) begin
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (oldElig[i]) begin
                            mIdn = 4'(i + 1);
                            break;
                        end
                    end
                    mPhase = PH_OFFER;
                end
            end
            PH_OFFER: begin
                if (ifc.intAck)
                    mPhase = PH_SERVICE;
                else if (!ifc.IE || !mMask[idx])
                    mPhase = PH_NONE;
            end
            default: begin
                if (ifc.intDone)
                    mPhase = PH_NONE;
            end
        endcase
        mPend = (mPend & ~clr) | (ifc.req & ~mPrev);
        if (ifc.we && ifc.ABUS == ADDR_MASK)
            mMask = tbData[3:0];
        mPrev = ifc.req;
    endtask

    task automatic tick();
        #1;
        if (!ifc.we && ifc.ABUS == ADDR_MASK)
            checkVal("rdMask", DBUS, {28'h0, mMask});
        else if (!ifc.we && ifc.ABUS == ADDR_PEND)
            checkVal("rdPend", DBUS, {28'h0, mPend});
        modelStep();
        @(posedge clk);
        #1;
        checkVal("IRQ", 32'(ifc.IRQ), 32'(mPhase == PH_OFFER));
        checkVal("busy", 32'(ifc.busy), 32'(mPhase == PH_SERVICE));
        checkVal("IDN", 32'(ifc.IDN), (mPhase == PH_NONE) ? 32'hF : 32'(mIdn));
    endtask

    task automatic readChk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        busRead(a);
        #1;
        checkVal(tag, DBUS, exp);
    endtask

    task automatic pulseAck();
        ifc.intAck = 1'b1;
        tick();
        ifc.intAck = 1'b0;
    endtask

    task automatic pulseDone();
        ifc.intDone = 1'b1;
        tick();
        ifc.intDone = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        ifc.IE      = 1'b1;
        ifc.req     = 4'h0;
        ifc.intAck  = 1'b0;
        ifc.intDone = 1'b0;
        busRead(ADDR_OTHER);
        mPend  = 4'h0;
        mMask  = 4'hF;
        mPrev  = 4'h0;
        mPhase = PH_NONE;
        mIdn   = 4'hF;
        @(posedge clk);
        #1;
        tick();
        rst = 1'b0;
        checkVal("rstIRQ", 32'(ifc.IRQ), 32'h0);
        checkVal("rstIDN", 32'(ifc.IDN), 32'hF);
        checkVal("rstBusy", 32'(ifc.busy), 32'h0);
        readChk("rstMask", ADDR_MASK, 32'hF);
        readChk("rstPend", ADDR_PEND, 32'h0);
        busRead(ADDR_OTHER);

        // Single request on switches, full handshake.
        ifc.req = 4'b0100;
        tick();
        checkVal("t1Early", 32'(ifc.IRQ), 32'h0);
        ifc.req = 4'b0000;
        tick();
        checkVal("t1IRQ", 32'(ifc.IRQ), 32'h1);
        checkVal("t1IDN", 32'(ifc.IDN), 32'h3);
        pulseAck();
        checkVal("t1Busy", 32'(ifc.busy), 32'h1);
        checkVal("t1IDNsvc", 32'(ifc.IDN), 32'h3);
        readChk("t1Pend", ADDR_PEND, 32'h0);
        busRead(ADDR_OTHER);
        pulseDone();
        checkVal("t1Done", 32'(ifc.IDN), 32'hF);

        // Simultaneous timer and keys: timer first, keys after one idle cycle.
        ifc.req = 4'b0011;
        tick();
        ifc.req = 4'b0000;
        tick();
        checkVal("t2First", 32'(ifc.IDN), 32'h1);
        pulseAck();
        pulseDone();
        checkVal("t2Gap", 32'(ifc.IRQ), 32'h0);
        tick();
        checkVal("t2IRQ", 32'(ifc.IRQ), 32'h1);
        checkVal("t2Second", 32'(ifc.IDN), 32'h2);

        // Drop IE while presenting keys, then restore it.
        ifc.IE = 1'b0;
        tick();
        checkVal("t4Drop", 32'(ifc.IRQ), 32'h0);
        readChk("t4Pend", ADDR_PEND, 32'h2);
        busRead(ADDR_OTHER);
        ifc.IE = 1'b1;
        tick();
        checkVal("t4Again", 32'(ifc.IDN), 32'h2);
        pulseAck();
        pulseDone();

        // Masked timer stays pending until the mask is reopened.
        busWrite(ADDR_MASK, 32'hE);
        tick();
        busRead(ADDR_OTHER);
        ifc.req = 4'b0001;
        tick();
        ifc.req = 4'b0000;
        tick();
        tick();
        checkVal("t3Masked", 32'(ifc.IRQ), 32'h0);
        readChk("t3Pend", ADDR_PEND, 32'h1);
        busWrite(ADDR_MASK, 32'hF);
        tick();
        busRead(ADDR_OTHER);
        tick();
        checkVal("t3IRQ", 32'(ifc.IRQ), 32'h1);
        checkVal("t3IDN", 32'(ifc.IDN), 32'h1);
        pulseAck();
        pulseDone();

        // Set beats write-1-to-clear in the same cycle.
        ifc.IE  = 1'b0;
        ifc.req = 4'b0010;
        busWrite(ADDR_PEND, 32'h2);
        tick();
        ifc.req = 4'b0000;
        readChk("t5SetWins", ADDR_PEND, 32'h2);
        busWrite(ADDR_PEND, 32'h2);
        tick();
        readChk("t5Cleared", ADDR_PEND, 32'h0);
        busRead(ADDR_OTHER);
        ifc.IE = 1'b1;

        // Reset while in service discards the interrupt and restores the mask.
        busWrite(ADDR_MASK, 32'h8);
        tick();
        busRead(ADDR_OTHER);
        ifc.req = 4'b1000;
        tick();
        ifc.req = 4'b0000;
        tick();
        pulseAck();
        checkVal("t6Svc", 32'(ifc.busy), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkVal("t6Busy", 32'(ifc.busy), 32'h0);
        checkVal("t6IRQ", 32'(ifc.IRQ), 32'h0);
        checkVal("t6IDN", 32'(ifc.IDN), 32'hF);
        readChk("t6Mask", ADDR_MASK, 32'hF);
        readChk("t6Pend", ADDR_PEND, 32'h0);
        busRead(ADDR_OTHER);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 199) == 0);
            ifc.IE      = ($urandom_range(0, 9) != 0);
            ifc.intAck  = ($urandom_range(0, 2) == 0);
            ifc.intDone = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NUM_SRC; i++)
                if ($urandom_range(0, 3) == 0)
                    ifc.req[i] = ~ifc.req[i];
            case ($urandom_range(0, 9))
                0:       busWrite(ADDR_MASK, $urandom);
                1:       busWrite(ADDR_PEND, $urandom);
                2, 3:    busRead(ADDR_MASK);
                4, 5:    busRead(ADDR_PEND);
                default: busRead(ADDR_OTHER);
            endcase
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/intr_arbiter.md
# intr_arbiter

Interrupt request arbiter between the memory-mapped I/O devices (timer, keys, switches, spare) and the system register file. It edge-captures device requests into sticky pending bits and filters them through a software-writable mask. It then selects one source by fixed priority and presents it as IRQ/IDN with an acknowledge/done handshake, so exactly one interrupt is in flight at a time. Mask and pending registers are on the processor's ABUS/DBUS for software access.

## Interface
- NUM_SRC, 4, number of request sources; source i reports IDN = i+1
- ADDR_MASK, 32'hF0000020, address of enable-mask register
- ADDR_PEND, 32'hF0000024, address of pending register (read / write-1-to-clear)
- IDN_NONE, 4'hF, IDN value when no interrupt is presented or in service

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- IE  in  1  global interrupt enable from system register file
- req  in  NUM_SRC  device request levels; bit 0 = timer, 1 = keys, 2 = switches, 3 = spare
- ABUS  in  32  data-memory address bus
- DBUS  inout  32  data bus; driven only on register reads, else high-Z
- we  in  1  bus write enable
- intAck  in  1  one-cycle pulse: CPU has taken the presented interrupt
- intDone  in  1  one-cycle pulse: handler returned (RETI)
- IRQ  out  1  interrupt request to CPU
- IDN  out  4  interrupt device number
- busy  out  1  an interrupt is in service

## Operation
- Edge capture: req_d registers req. pending[i] sets when req[i] & ~req_d[i].
- pending[i] clears on intAck while in REQ with cur == i, or on a bus write to ADDR_PEND with DBUS[i]=1.
- If a set and a clear of the same bit occur in the same cycle, set wins.
- mask: NUM_SRC bits, written from DBUS[NUM_SRC-1:0] when we && ABUS==ADDR_MASK.
- eligible = pending & mask. Winner = lowest-index set bit of eligible (timer highest priority).
- FSM states:
  - IDLE: IRQ=0, busy=0, IDN=IDN_NONE. If IE && |eligible, latch winner index into cur and go to REQ.
  - REQ: IRQ=1, IDN=cur+1, busy=0. On intAck, clear pending[cur] and go to SVC. Otherwise, if IE==0 or mask[cur]==0, go to IDLE with pending kept (re-arbitrates later). cur does not change while in REQ, even if a higher-priority source arrives.
  - SVC: IRQ=0, busy=1, IDN=cur+1 (held for the handler to read). On intDone, go to IDLE. New edges still set pending. No nesting.
- intAck outside REQ and intDone outside SVC are ignored.
- Bus reads (we=0) drive DBUS combinationally:
  - ABUS==ADDR_MASK: zero-extended mask
  - ABUS==ADDR_PEND: zero-extended pending
  - any other address: high-Z
- Never drive DBUS while we=1.
- Width rules: cur is 2 bits for NUM_SRC=4 (ceil log2). IDN = {zero-pad, cur} + 1, which fits 4 bits for NUM_SRC ≤ 14.

## Timing
- Reset values: state=IDLE, pending=0, req_d=0, mask=all ones, cur=0, IRQ=0, IDN=IDN_NONE, busy=0, DBUS high-Z.
- req[i] rises in cycle n: pending[i]=1 after edge n; state=REQ and IRQ=1 after edge n+1. Request-to-IRQ latency is 2 cycles.
- intAck sampled in cycle m (REQ): IRQ=0 and busy=1 from edge m. IDN unchanged.
- intDone sampled in cycle k (SVC): IDLE from edge k. If eligible is nonzero and IE=1, IRQ reasserts after edge k+1 (1 idle cycle minimum between interrupts).
- A bus write takes effect at the following edge. Reads are same-cycle combinational.
- rst asserted in any state returns all registers to reset values on that edge. An interrupt in progress is discarded.
- A held-high req produces one pending event. A new event needs req low for ≥1 cycle.

## Test plan
- Reset, then pulse req[2] for 1 cycle with IE=1 -> IRQ=1, IDN=3 two cycles later. intAck -> IRQ=0, busy=1, pending=0. intDone -> busy=0, IDN=4'hF.
- req[0] and req[1] rise in the same cycle -> IDN=1 first. After ack+done, IDN=2 presented with IRQ=1 two cycles later.
- Write mask=4'b1110, pulse req[0] -> IRQ stays 0 and a read of ADDR_PEND returns 32'h1. Write mask=4'hF -> IRQ=1, IDN=1.
- In REQ with IDN=2, drop IE -> IRQ=0 next cycle, pending[1] still 1. Raise IE -> IRQ=1, IDN=2 again.
- Pulse req[1] on the same cycle as a write of 32'h2 to ADDR_PEND -> pending[1]=1 (set wins). Write 32'h2 again with no edge -> pending=0.
- Assert rst while in SVC -> next cycle busy=0, IRQ=0, IDN=4'hF, mask reads 32'hF, pending reads 0.
